mc_main_ctrl: RTL and testbench

- Main control FSM for the multicycle CPU datapath.
- Sequences the five-bit write-register select mux through RegDst, along with the PC, memory, IR, ALU-source and register-file write enables.
- Decodes the 6-bit opcode latched in IR. Stalls on a memory ready handshake.
- Sits between the IR opcode field and all datapath select/enable pins.

---
 rtl/mc_ctrl_pkg.sv | 85 ++++++++
 rtl/mc_ctrl_decode.sv | 98 +++++++++
 rtl/mc_main_ctrl.sv | 114 +++++++++++
 tb/tb_mc_main_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
//  Module      : mc_ctrl_pkg
//  Description : Shared encodings for the multicycle CPU main controller:
//                state codes, opcodes, datapath select codes and the packed
//                control-word layout. Optional feature macro:
//                MC_CTRL_ADDI_EN (adds the ADDI execute/writeback path).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

  // State encodings
  localparam int ST_BITS = 4;
  typedef logic [ST_BITS-1:0] state_t;

  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_FETCH   = 4'd1;
  localparam state_t ST_DECODE  = 4'd2;
  localparam state_t ST_MEMADR  = 4'd3;
  localparam state_t ST_MEMRD   = 4'd4;
  localparam state_t ST_MEMWB   = 4'd5;
  localparam state_t ST_MEMWR   = 4'd6;
  localparam state_t ST_R_EX    = 4'd7;
  localparam state_t ST_R_WB    = 4'd8;
  localparam state_t ST_BEQ     = 4'd9;
  localparam state_t ST_JMP     = 4'd10;
  localparam state_t ST_ADDI_EX = 4'd11;
  localparam state_t ST_ADDI_WB = 4'd12;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // ALUOp codes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB codes
  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // PCSource codes
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // Control word produced by the state decoder
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // True for every opcode the DECODE state knows how to dispatch
  function automatic logic op_is_known(input logic [5:0] op);
    logic known;
    known = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
            (op == OP_BEQ)   || (op == OP_J);
`ifdef MC_CTRL_ADDI_EN
    known = known || (op == OP_ADDI);
`endif
    return known;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
// ============================================================================
//  Module      : mc_ctrl_decode
//  Description : Pure combinational Moore decode of controller state into the
//                datapath control word. Fetch strobes are emitted ungated;
//                the top qualifies them with mem_ready.
//                Optional feature macro: MC_CTRL_ADDI_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t i_state,
  output ctrl_t  o_ctrl
);

  ctrl_t w_ctrl;

  // Map each state to its control word; anything unlisted stays zero
  always_comb begin
    w_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.iord      = 1'b0;
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.pc_source = PCSRC_ALU;
        w_ctrl.ir_write  = 1'b1;
        w_ctrl.pc_write  = 1'b1;
      end
      ST_DECODE: begin
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = SRCB_IMM_SH;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
      end
      ST_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
      end
      ST_MEMWR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.iord      = 1'b1;
      end
      ST_R_EX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_B;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b0;
        w_ctrl.reg_dst    = 1'b1;
      end
      ST_BEQ: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRCB_B;
        w_ctrl.alu_op        = ALUOP_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JMP: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MC_CTRL_ADDI_EN
      ST_ADDI_EX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_ADDI_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b0;
        w_ctrl.reg_dst    = 1'b0;
      end
`endif
      default: w_ctrl = '0;
    endcase
  end

  assign o_ctrl = w_ctrl;

endmodule

`default_nettype wire

// File: rtl/mc_main_ctrl.sv
// ============================================================================
//  Module      : mc_main_ctrl
//  Description : Main control FSM of the multicycle CPU. Holds the state
//                register and next-state logic, dispatches on the IR opcode,
//                stalls on the memory ready handshake and drives all datapath
//                selects/enables. Optional feature macro: MC_CTRL_ADDI_EN
//                (ADDI execute + writeback states).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_main_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      Op,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            MemtoReg,
  output logic            RegDst,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSource,
  output logic            illegal_op,
  output logic [ST_W-1:0] dbg_state
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  logic   w_fetch_go;

  // State register; reset drops straight to IDLE so every strobe falls at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection; Op is only looked at in DECODE and MEMADR
  always_comb begin
    w_next = ST_FETCH;
    case (r_state)
      ST_IDLE:   w_next = ST_FETCH;
      ST_FETCH:  w_next = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (Op)
          OP_LW,
          OP_SW:    w_next = ST_MEMADR;
          OP_RTYPE: w_next = ST_R_EX;
          OP_BEQ:   w_next = ST_BEQ;
          OP_J:     w_next = ST_JMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:  w_next = ST_ADDI_EX;
`endif
          default:  w_next = ST_FETCH;
        endcase
      end
      ST_MEMADR: w_next = (Op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  w_next = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  w_next = ST_FETCH;
      ST_MEMWR:  w_next = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_R_EX:   w_next = ST_R_WB;
      ST_R_WB:   w_next = ST_FETCH;
      ST_BEQ:    w_next = ST_FETCH;
      ST_JMP:    w_next = ST_FETCH;
`ifdef MC_CTRL_ADDI_EN
      ST_ADDI_EX: w_next = ST_ADDI_WB;
      ST_ADDI_WB: w_next = ST_FETCH;
`endif
      default:   w_next = ST_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Output stage: IR/PC loads in FETCH wait for the memory handshake
  always_comb begin
    w_fetch_go  = (r_state != ST_FETCH) || mem_ready;
    PCWrite     = w_ctrl.pc_write & w_fetch_go;
    IRWrite     = w_ctrl.ir_write & w_fetch_go;
    PCWriteCond = w_ctrl.pc_write_cond;
    IorD        = w_ctrl.iord;
    MemRead     = w_ctrl.mem_read;
    MemWrite    = w_ctrl.mem_write;
    MemtoReg    = w_ctrl.mem_to_reg;
    RegDst      = w_ctrl.reg_dst;
    RegWrite    = w_ctrl.reg_write;
    ALUSrcA     = w_ctrl.alu_src_a;
    ALUSrcB     = w_ctrl.alu_src_b;
    ALUOp       = w_ctrl.alu_op;
    PCSource    = w_ctrl.pc_source;
    illegal_op  = (r_state == ST_DECODE) && !op_is_known(Op);
    dbg_state   = ST_W'(r_state);
  end

endmodule

`default_nettype wire

// File: tb/tb_mc_main_ctrl.sv
// ============================================================================
//  Module      : tb_mc_main_ctrl
//  Description : Directed table-driven bench for mc_main_ctrl plus a
//                hand-written mid-instruction reset sequence.
//                Honours MC_CTRL_ADDI_EN for the opcode 0x08 vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_main_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Op = 6'h3F;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] dbg_state;

  mc_main_ctrl #(.ST_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Op          (Op),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .illegal_op  (illegal_op),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // Observed control word, bit order:
  // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst
  // RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0]
  logic [15:0] w_obs;
  assign w_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  // Hand-computed expected control words per state
  localparam logic [15:0] C_ZERO   = 16'h0000;
  localparam logic [15:0] C_FSTALL = 16'h1010;
  localparam logic [15:0] C_FETCH  = 16'h9410;
  localparam logic [15:0] C_DECODE = 16'h0030;
  localparam logic [15:0] C_MEMADR = 16'h0060;
  localparam logic [15:0] C_MEMRD  = 16'h3000;
  localparam logic [15:0] C_MEMWB  = 16'h0280;
  localparam logic [15:0] C_MEMWR  = 16'h2800;
  localparam logic [15:0] C_R_EX   = 16'h0048;
  localparam logic [15:0] C_R_WB   = 16'h0180;
  localparam logic [15:0] C_BEQ    = 16'h4045;
  localparam logic [15:0] C_JMP    = 16'h8002;
  localparam logic [15:0] C_ADDIEX = 16'h0060;
  localparam logic [15:0] C_ADDIWB = 16'h0080;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void add(input logic r, input logic [5:0] o, input logic rd,
                              input logic [3:0] s, input logic [15:0] c,
                              input logic il);
    vec_t v;
    v.rst_n = r; v.op = o; v.rdy = rd; v.st = s; v.ctl = c; v.ill = il;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, got, exp, $time);
  endtask

  task automatic check_all(input string tag, input logic [3:0] s,
                           input logic [15:0] c, input logic il);
    check({tag, " state"}, {12'd0, dbg_state}, {12'd0, s});
    check({tag, " ctrl"}, w_obs, c);
    check({tag, " illegal"}, {15'd0, illegal_op}, {15'd0, il});
    check({tag, " rw-excl"}, {15'd0, RegWrite & (MemWrite | IRWrite)}, 16'd0);
  endtask

  initial begin
    // Each row: inputs for one cycle and the outputs expected in that cycle
    add(0, 6'h3F, 1, 4'd0,  C_ZERO,   0);  // in reset
    add(1, 6'h3F, 1, 4'd0,  C_ZERO,   0);  // IDLE quiet cycle
    // lw, zero wait
    add(1, 6'h3F, 1, 4'd1,  C_FETCH,  0);
    add(1, 6'h23, 1, 4'd2,  C_DECODE, 0);
    add(1, 6'h23, 1, 4'd3,  C_MEMADR, 0);
    add(1, 6'h3F, 1, 4'd4,  C_MEMRD,  0);
    add(1, 6'h3F, 1, 4'd5,  C_MEMWB,  0);
    // R-type
    add(1, 6'h3F, 1, 4'd1,  C_FETCH,  0);
    add(1, 6'h00, 1, 4'd2,  C_DECODE, 0);
    add(1, 6'h3F, 1, 4'd7,  C_R_EX,   0);
    add(1, 6'h3F, 1, 4'd8,  C_R_WB,   0);
    // fetch stall x3 then beq
    add(1, 6'h3F, 0, 4'd1,  C_FSTALL, 0);
    add(1, 6'h3F, 0, 4'd1,  C_FSTALL, 0);
    add(1, 6'h3F, 0, 4'd1,  C_FSTALL, 0);
    add(1, 6'h3F, 1, 4'd1,  C_FETCH,  0);
    add(1, 6'h04, 1, 4'd2,  C_DECODE, 0);
    add(1, 6'h3F, 1, 4'd9,  C_BEQ,    0);
    // j
    add(1, 6'h3F, 1, 4'd1,  C_FETCH,  0);
    add(1, 6'h02, 1, 4'd2,  C_DECODE, 0);
    add(1, 6'h3F, 1, 4'd10, C_JMP,    0);
    // sw with two wait cycles
    add(1, 6'h3F, 1, 4'd1,  C_FETCH,  0);
    add(1, 6'h2B, 1, 4'd2,  C_DECODE, 0);
    add(1, 6'h2B, 1, 4'd3,  C_MEMADR, 0);
    add(1, 6'h23, 0, 4'd6,  C_MEMWR,  0);
    add(1, 6'h23, 0, 4'd6,  C_MEMWR,  0);
    add(1, 6'h23, 1, 4'd6,  C_MEMWR,  0);
    // lw with one wait in MEMRD; op changes in MEMRD are ignored
    add(1, 6'h3F, 1, 4'd1,  C_FETCH,  0);
    add(1, 6'h23, 1, 4'd2,  C_DECODE, 0);
    add(1, 6'h23, 1, 4'd3,  C_MEMADR, 0);
    add(1, 6'h2B, 0, 4'd4,  C_MEMRD,  0);
    add(1, 6'h00, 1, 4'd4,  C_MEMRD,  0);
    add(1, 6'h3F, 1, 4'd5,  C_MEMWB,  0);
    // unknown opcode
    add(1, 6'h3F, 1, 4'd1,  C_FETCH,  0);
    add(1, 6'h3F, 1, 4'd2,  C_DECODE, 1);
    // opcode 0x08
    add(1, 6'h3F, 1, 4'd1,  C_FETCH,  0);
`ifdef MC_CTRL_ADDI_EN
    add(1, 6'h08, 1, 4'd2,  C_DECODE, 0);
    add(1, 6'h3F, 1, 4'd11, C_ADDIEX, 0);
    add(1, 6'h3F, 1, 4'd12, C_ADDIWB, 0);
`else
    add(1, 6'h08, 1, 4'd2,  C_DECODE, 1);
`endif
    add(1, 6'h3F, 0, 4'd1,  C_FSTALL, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n     = vecs[i].rst_n;
      Op        = vecs[i].op;
      mem_ready = vecs[i].rdy;
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctl, vecs[i].ill);
    end

    // Reset in the middle of a store wait: strobes must drop without a clock
    @(negedge clk); Op = 6'h3F; mem_ready = 1'b1;            // FETCH -> DECODE
    @(negedge clk); Op = 6'h2B;                              // DECODE
    @(negedge clk); Op = 6'h2B;                              // MEMADR
    @(negedge clk); mem_ready = 1'b0; #1;
    check_all("rst pre", 4'd6, C_MEMWR, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all("rst async", 4'd0, C_ZERO, 1'b0);
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1;
    check_all("rst idle", 4'd0, C_ZERO, 1'b0);
    @(negedge clk); #1;
    check_all("rst fetch", 4'd1, C_FSTALL, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
